// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit sequencer.
// Optional parity support is selected by the TX_PARITY_EN macro in the users of this package.
package uart_tx_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_STOP  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity of the latched transmit word (even when par_typ=0, odd when 1).
// Only present when TX_PARITY_EN is defined.
`ifdef TX_PARITY_EN
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // NOTE: a continuous assign cannot infer a latch, unlike a partially-assigned always block.
    assign par_bit = (^data) ^ par_typ;

endmodule
`endif

// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer: IDLE -> START -> DATA -> [PARITY] -> STOP, one bit per clock, LSB first.
// The PARITY state and parity logic exist only when TX_PARITY_EN is defined.
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_fsm,
    input  logic                  rst_fsm,
    input  logic [DATA_WIDTH-1:0] p_data_fsm,
    input  logic                  data_valid_fsm,
    input  logic                  par_en_fsm,
    input  logic                  par_typ_fsm,
    output logic [1:0]            mux_sel_fsm,
    output logic                  ser_data_fsm,
    output logic                  par_bit_fsm,
    output logic                  busy_fsm
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        next_cnt;
    logic                    accept;

    // New words are taken only when idle or on the STOP exit edge (back-to-back frames).
    assign accept   = data_valid_fsm && ((state == IDLE) || (state == STOP));
    assign next_cnt = bit_cnt + 1'b1;

`ifdef TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic par_calc;
    logic par_bit_q;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_calc)
    );

    assign par_bit_fsm = par_bit_q;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = par_en_fsm ^ par_typ_fsm;
    assign par_bit_fsm    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_fsm or posedge rst_fsm) begin
        if (rst_fsm) begin
            state        <= IDLE;
            data_q       <= '0;
            bit_cnt      <= '0;
            mux_sel_fsm  <= SEL_STOP;
            ser_data_fsm <= 1'b0;
            busy_fsm     <= 1'b0;
`ifdef TX_PARITY_EN
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bit_q    <= 1'b0;
`endif
        end else begin
            ser_data_fsm <= 1'b0;
            case (state)
                IDLE, STOP: begin
                    if (accept) begin
                        data_q      <= p_data_fsm;
`ifdef TX_PARITY_EN
                        par_en_q    <= par_en_fsm;
                        par_typ_q   <= par_typ_fsm;
`endif
                        state       <= START;
                        mux_sel_fsm <= SEL_START;
                        busy_fsm    <= 1'b1;
                    end else begin
                        state       <= IDLE;
                        mux_sel_fsm <= SEL_STOP;
                        busy_fsm    <= 1'b0;
                    end
                end
                START: begin
                    state        <= DATA;
                    mux_sel_fsm  <= SEL_DATA;
                    bit_cnt      <= '0;
                    ser_data_fsm <= data_q[0];
                end
                DATA: begin
                    bit_cnt <= next_cnt;
                    if (bit_cnt == LAST_BIT) begin
`ifdef TX_PARITY_EN
                        if (par_en_q) begin
                            state       <= PARITY;
                            mux_sel_fsm <= SEL_PAR;
                            par_bit_q   <= par_calc;
                        end else
`endif
                        begin
                            state       <= STOP;
                            mux_sel_fsm <= SEL_STOP;
                        end
                    end else begin
                        ser_data_fsm <= data_q[next_cnt];
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    state       <= STOP;
                    mux_sel_fsm <= SEL_STOP;
                end
`endif
                default: begin
                    state       <= IDLE;
                    mux_sel_fsm <= SEL_STOP;
                    busy_fsm    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: directed frames plus random traffic against a frame-list model.
// Works with TX_PARITY_EN defined or undefined.
module tb_uart_tx_fsm;
    import uart_tx_pkg::*;

    localparam int W = 8;
`ifdef TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif
    localparam int FRAME_PAR   = W + 2 + (PAR_BUILD ? 1 : 0);
    localparam int FRAME_NOPAR = W + 2;

    logic         clk_fsm = 1'b0;
    logic         rst_fsm = 1'b1;
    logic [W-1:0] p_data_fsm = '0;
    logic         data_valid_fsm = 1'b0;
    logic         par_en_fsm = 1'b0;
    logic         par_typ_fsm = 1'b0;
    logic [1:0]   mux_sel_fsm;
    logic         ser_data_fsm;
    logic         par_bit_fsm;
    logic         busy_fsm;

    always #5 clk_fsm = ~clk_fsm;

    uart_tx_fsm #(
        .DATA_WIDTH (W)
    ) dut (
        .clk_fsm        (clk_fsm),
        .rst_fsm        (rst_fsm),
        .p_data_fsm     (p_data_fsm),
        .data_valid_fsm (data_valid_fsm),
        .par_en_fsm     (par_en_fsm),
        .par_typ_fsm    (par_typ_fsm),
        .mux_sel_fsm    (mux_sel_fsm),
        .ser_data_fsm   (ser_data_fsm),
        .par_bit_fsm    (par_bit_fsm),
        .busy_fsm       (busy_fsm)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic       ser;
        logic       par;
        logic       busy;
    } exp_t;

    localparam exp_t IDLE_EXP = '{sel: SEL_STOP, ser: 1'b0, par: 1'b0, busy: 1'b0};

    exp_t q[$];
    exp_t exp_cur;
    int   errors = 0;
    int   checks = 0;
    int   busy_cycles = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Expected per-cycle outputs of one whole frame, straight from the frame format.
    task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        q.push_back('{sel: SEL_START, ser: 1'b0, par: 1'b0, busy: 1'b1});
        for (int i = 0; i < W; i++)
            q.push_back('{sel: SEL_DATA, ser: d[i], par: 1'b0, busy: 1'b1});
        if (pe && PAR_BUILD)
            q.push_back('{sel: SEL_PAR, ser: 1'b0, par: (^d) ^ pt, busy: 1'b1});
        q.push_back('{sel: SEL_STOP, ser: 1'b0, par: 1'b0, busy: 1'b1});
    endtask

    task automatic compare_now();
        check("mux_sel", 32'(mux_sel_fsm), 32'(exp_cur.sel));
        check("busy", 32'(busy_fsm), 32'(exp_cur.busy));
        if (exp_cur.sel == SEL_DATA) check("ser_data", 32'(ser_data_fsm), 32'(exp_cur.ser));
        if (exp_cur.sel == SEL_PAR)  check("par_bit", 32'(par_bit_fsm), 32'(exp_cur.par));
        if (busy_fsm === 1'b1) busy_cycles++;
    endtask

    // Called just after a falling edge: check this cycle, drive inputs, advance the model one cycle.
    task automatic cycle(input logic dv, input logic [W-1:0] d, input logic pe, input logic pt);
        compare_now();
        data_valid_fsm = dv;
        p_data_fsm     = d;
        par_en_fsm     = pe;
        par_typ_fsm    = pt;
        if (q.size() == 0 && dv) push_frame(d, pe, pt);
        if (q.size() > 0) exp_cur = q.pop_front();
        else              exp_cur = IDLE_EXP;
        @(negedge clk_fsm);
    endtask

    task automatic reset_mid();
        compare_now();
        data_valid_fsm = 1'b0;
        #2 rst_fsm = 1'b1;
        #1;
        check("rst_mid_mux_sel", 32'(mux_sel_fsm), 32'(SEL_STOP));
        check("rst_mid_busy", 32'(busy_fsm), 32'd0);
        check("rst_mid_ser_data", 32'(ser_data_fsm), 32'd0);
        @(negedge clk_fsm);
        rst_fsm = 1'b0;
        q.delete();
        exp_cur = IDLE_EXP;
    endtask

    initial begin
        logic         r_dv;
        logic [W-1:0] r_d;
        logic         r_pe;
        logic         r_pt;

        exp_cur = IDLE_EXP;
        repeat (2) @(negedge clk_fsm);
        check("reset_mux_sel", 32'(mux_sel_fsm), 32'(SEL_STOP));
        check("reset_ser_data", 32'(ser_data_fsm), 32'd0);
        check("reset_par_bit", 32'(par_bit_fsm), 32'd0);
        check("reset_busy", 32'(busy_fsm), 32'd0);
        rst_fsm = 1'b0;
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);

        // Even parity 0xA5
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (FRAME_PAR + 1) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Odd parity 0x00, busy length
        busy_cycles = 0;
        cycle(1'b1, 8'h00, 1'b1, 1'b1);
        repeat (FRAME_PAR + 2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("busy_len_odd", 32'(busy_cycles), 32'(FRAME_PAR));

        // No parity 0xFF
        busy_cycles = 0;
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        repeat (FRAME_NOPAR + 2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("busy_len_nopar", 32'(busy_cycles), 32'(FRAME_NOPAR));

        // Back-to-back 0x3C then 0xC3, data_valid held through STOP
        busy_cycles = 0;
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        repeat (FRAME_PAR) cycle(1'b1, 8'hC3, 1'b1, 1'b0);
        repeat (FRAME_PAR + 2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("busy_len_b2b", 32'(busy_cycles), 32'(2 * FRAME_PAR));

        // Request during DATA is ignored
        cycle(1'b1, 8'h0F, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        repeat (FRAME_PAR + 1) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset during DATA bit 3, then a fresh 0x81 frame
        cycle(1'b1, 8'h0F, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        reset_mid();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h81, 1'b1, 1'b0);
        repeat (FRAME_PAR + 1) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            r_dv = ($urandom_range(0, 3) == 0);
            r_d  = W'($urandom);
            r_pe = 1'($urandom);
            r_pt = 1'($urandom);
            cycle(r_dv, r_d, r_pe, r_pt);
        end
        repeat (FRAME_PAR + 1) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
